clstm_output_serializer: RTL and testbench
==========================================

// Module: clstm_output_serializer
// PURPOSE
//  Downstream stage of the C-LSTM datapath. Captures one complete result frame
//  (NUM_GROUPS x NUM_LANES words, e.g. 3 x 16 x 18-bit) in a single cycle when the
//  datapath presents it. Then streams the frame out one word per beat over a
//  valid/ready interface, in group-major, lane-minor order. Replaces the static
//  group/lane select mux with a flow-controlled, back-pressurable output port.
// PARAMETERS
//  DATA_W       18  width of one datapath result word
//  NUM_GROUPS   3   result groups per frame
//  NUM_LANES    16  lanes per group
//  FRAME_CNT_W  16  width of completed-frame counter (wraps)
// PORTS
//  clk          in   1                      single clock, rising edge
//  rst          in   1                      asynchronous, active-low reset
//  in_valid     in   1                      datapath frame valid
//  in_ready     out  1                      serializer can accept a frame this cycle
//  in_data      in   NUM_GROUPS*NUM_LANES*DATA_W  frame; word k at [k*DATA_W +: DATA_W], k=g*NUM_LANES+l
//  out_valid    out  1                      out_data holds a valid word
//  out_ready    in   1                      consumer accepts word
//  out_data     out  DATA_W                 current word
//  out_group    out  $clog2(NUM_GROUPS)     group index g of current word
//  out_lane     out  $clog2(NUM_LANES)      lane index l of current word
//  out_last     out  1                      current word is the last word of the frame (k=N-1)
//  frame_count  out  FRAME_CNT_W            number of fully emitted frames, modulo 2^FRAME_CNT_W
// BEHAVIOUR
//  N = NUM_GROUPS*NUM_LANES. Storage: N-word frame buffer; word index idx; 2-state FSM.
//  Reset (rst=0, async): FSM=IDLE, idx=0, buffer all zeros, frame_count=0.
//   Outputs under reset: out_valid=0, out_data=0, out_group=0, out_lane=0,
//   out_last=0, in_ready=1.
//  IDLE: in_ready=1, out_valid=0. On in_valid: capture all N words, idx<=0,
//   go to STREAM.
//  STREAM: out_valid=1; out_data=buf[idx], out_group=idx/NUM_LANES,
//   out_lane=idx%NUM_LANES, out_last=(idx==N-1).
//   Beat = out_valid && out_ready.
//   Beat with idx<N-1: idx<=idx+1.
//   Beat with idx==N-1: frame_count<=frame_count+1 (wraps). Then:
//    - if in_valid in the same cycle: capture new frame, idx<=0, stay in STREAM;
//    - otherwise go to IDLE.
//  in_ready = IDLE || (STREAM && idx==N-1 && out_ready). This is combinational
//   from out_ready and gives zero-bubble back-to-back frames.
//  Latency: frame captured at edge E gives word 0 with out_valid=1 in the cycle after E.
//   Full frame takes N cycles at out_ready=1.
//  Backpressure: while out_valid && !out_ready, out_data, out_group, out_lane
//   and out_last hold stable. No word is skipped or repeated.
//  in_valid while in_ready=0 has no effect. Upstream holds in_valid and in_data
//   until in_ready.
//  out_valid never drops mid-frame. Once asserted it stays high until the last beat.
//  Reset mid-frame: frame aborted, no frame_count increment, all reset values
//   restored immediately.
//  Data is passed through unmodified. No arithmetic on words; bit-exact with in_data.
// TESTING
//  T1 reset: hold rst=0 with in_valid=1 -> out_valid=0, in_ready=1, frame_count=0,
//     out_data=0 throughout.
//  T2 single frame: word k = k+18'h100, out_ready=1 -> beats 1..48 carry 18'h100..18'h12F.
//     g/l go (0,0)..(2,15); out_last only on beat 48; in_ready=0 on beats 1..47;
//     frame_count=1 after.
//  T3 backpressure: out_ready pseudo-random at 30% -> the same 48 words arrive in order.
//     Outputs are stable during every stall; frame_count=1.
//  T4 back-to-back: frame B (word k = ~k) presented with in_valid held through A's
//     last beat -> B word 0 appears the next cycle with no out_valid gap.
//     frame_count steps 1 then 2.
//  T5 reset mid-stream: assert rst during beat 20 of a frame -> out_valid=0
//     asynchronously and frame_count=0. The next frame after release starts at
//     word 0 of the new data.
//  T6 wrap: FRAME_CNT_W=4, stream 17 frames -> frame_count reads 1 at end;
//     no data corruption across the wrap.

Source files
------------

// File: rtl/clstm_output_serializer.sv
// Output serializer for the C-LSTM datapath: captures a whole result frame in one
// cycle, then streams it word by word (group-major, lane-minor) over valid/ready.
module clstm_output_serializer #(
    parameter  int DATA_W      = 18,
    parameter  int NUM_GROUPS  = 3,
    parameter  int NUM_LANES   = 16,
    parameter  int FRAME_CNT_W = 16,
    localparam int N           = NUM_GROUPS * NUM_LANES,
    localparam int G_W         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
    localparam int L_W         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*DATA_W-1:0]      in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [G_W-1:0]           out_group,
    output logic [L_W-1:0]           out_lane,
    output logic                     out_last,
    output logic [FRAME_CNT_W-1:0]   frame_count
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LANES_IDX = IDX_W'(NUM_LANES);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_STREAM = 1'b1;

    logic                   state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]      buf_q [N];
    logic                   capture;
    logic                   streaming;
    logic                   at_last;

    assign streaming = (state_q == ST_STREAM);
    assign at_last   = streaming && (idx_q == LAST_IDX);

    // Opens on the final beat so the next frame lands with no bubble on out_valid.
    assign in_ready  = !streaming || (at_last && out_ready);

    // NOTE: combinational next-state logic uses blocking '=' and assigns every
    // output a default first, so no latch can be inferred on an untaken path.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!streaming) begin
            if (in_valid) begin
                capture = 1'b1;
                idx_d   = '0;
                state_d = ST_STREAM;
            end
        end else if (out_ready) begin
            if (!at_last) begin
                idx_d = idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the frame buffer is reset to zero so nothing stale can ever be
    // observed after an aborted frame; this costs a reset net on every bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                buf_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < N; k++) begin
                buf_q[k] <= in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Outputs are forced to zero outside STREAM so idle/reset values are clean.
    assign out_valid   = streaming;
    assign out_data    = streaming ? buf_q[idx_q] : '0;
    assign out_group   = streaming ? G_W'(idx_q / LANES_IDX) : '0;
    assign out_lane    = streaming ? L_W'(idx_q % LANES_IDX) : '0;
    assign out_last    = at_last;
    assign frame_count = cnt_q;

endmodule

// File: tb/tb_clstm_output_serializer.sv
// Self-checking bench for clstm_output_serializer: a queue-based reference model
// of the emitted word stream plus directed scenarios with hand-computed literals.
module tb_clstm_output_serializer;

    localparam int DATA_W      = 18;
    localparam int NUM_GROUPS  = 3;
    localparam int NUM_LANES   = 16;
    localparam int FRAME_CNT_W = 4;
    localparam int N           = NUM_GROUPS * NUM_LANES;

    typedef logic [N*DATA_W-1:0] frame_t;
    typedef struct {
        logic [DATA_W-1:0] d;
        int                g;
        int                l;
        bit                last;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    frame_t                 in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic [1:0]             out_group;
    logic [3:0]             out_lane;
    logic                   out_last;
    logic [FRAME_CNT_W-1:0] frame_count;

    clstm_output_serializer #(
        .DATA_W(DATA_W), .NUM_GROUPS(NUM_GROUPS),
        .NUM_LANES(NUM_LANES), .FRAME_CNT_W(FRAME_CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_group(out_group), .out_lane(out_lane), .out_last(out_last),
        .frame_count(frame_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pending words of accepted frames, and completed-frame count.
    exp_t                   exp_q[$];
    logic [FRAME_CNT_W-1:0] cnt_m;
    bit                     beat_f;
    bit                     acc_f;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_out_data", 64'(out_data), 64'd0);
            check("rst_out_group", 64'(out_group), 64'd0);
            check("rst_out_lane", 64'(out_lane), 64'd0);
            check("rst_out_last", 64'(out_last), 64'd0);
            check("rst_frame_count", 64'(frame_count), 64'd0);
            beat_f = 1'b0;
            acc_f  = 1'b0;
        end else begin
            bit exp_v;
            bit exp_rdy;
            exp_v   = (exp_q.size() > 0);
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            check("out_valid", 64'(out_valid), 64'(exp_v));
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            check("frame_count", 64'(frame_count), 64'(cnt_m));
            if (exp_v) begin
                check("out_data", 64'(out_data), 64'(exp_q[0].d));
                check("out_group", 64'(out_group), 64'(exp_q[0].g));
                check("out_lane", 64'(out_lane), 64'(exp_q[0].l));
                check("out_last", 64'(out_last), 64'(exp_q[0].last));
            end
            beat_f = exp_v && out_ready;
            acc_f  = in_valid && exp_rdy;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            cnt_m = '0;
        end else begin
            if (beat_f) begin
                if (exp_q[0].last) cnt_m = cnt_m + 1'b1;
                void'(exp_q.pop_front());
            end
            if (acc_f) begin
                for (int k = 0; k < N; k++) begin
                    exp_t e;
                    e.d    = in_data[k*DATA_W +: DATA_W];
                    e.g    = k / NUM_LANES;
                    e.l    = k % NUM_LANES;
                    e.last = (k == N - 1);
                    exp_q.push_back(e);
                end
            end
        end
    end

    // out_ready driver: mode 0 always ready, mode 1 ready about 30% of cycles.
    int ready_mode = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
        end
    end

    function automatic frame_t make_frame(input int kind);
        frame_t f;
        logic [DATA_W-1:0] w;
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       w = DATA_W'(k + 'h100);
                1:       w = ~DATA_W'(k);
                default: w = DATA_W'($urandom);
            endcase
            f[k*DATA_W +: DATA_W] = w;
        end
        return f;
    endfunction

    task automatic send_frame(input frame_t f);
        bit ok = 1'b0;
        in_data  = f;
        in_valid = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = make_frame(0);

        // T1: reset held with in_valid asserted
        repeat (4) @(negedge clk);
        #1;
        check("t1_out_valid", 64'(out_valid), 64'd0);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        check("t1_out_data", 64'(out_data), 64'd0);
        check("t1_frame_count", 64'(frame_count), 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;

        // T2: single frame, always ready
        send_frame(make_frame(0));
        @(negedge clk);
        check("t2_word0_data", 64'(out_data), 64'h100);
        check("t2_word0_valid", 64'(out_valid), 64'd1);
        wait_idle();
        check("t2_frame_count", 64'(frame_count), 64'd1);

        // T3: backpressure
        do_reset();
        ready_mode = 1;
        send_frame(make_frame(0));
        wait_idle();
        check("t3_frame_count", 64'(frame_count), 64'd1);
        ready_mode = 0;

        // T4: back-to-back frames, B presented while A streams
        do_reset();
        send_frame(make_frame(0));
        send_frame(make_frame(1));
        @(negedge clk);
        check("t4_b_word0_data", 64'(out_data), 64'h3FFFF);
        check("t4_b_word0_valid", 64'(out_valid), 64'd1);
        check("t4_count_after_a", 64'(frame_count), 64'd1);
        wait_idle();
        check("t4_count_after_b", 64'(frame_count), 64'd2);

        // T5: reset during beat 20 (frame_count is 2 beforehand)
        send_frame(make_frame(2));
        begin
            bit ok = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (exp_q.size() == N - 19) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) check("t5_beat_timeout", 64'd0, 64'd1);
        end
        #1 rst = 1'b0;
        #1;
        check("t5_async_out_valid", 64'(out_valid), 64'd0);
        check("t5_async_count", 64'(frame_count), 64'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        send_frame(make_frame(0));
        @(negedge clk);
        check("t5_new_word0", 64'(out_data), 64'h100);
        wait_idle();
        check("t5_count_after", 64'(frame_count), 64'd1);

        // T6: 17 frames with a 4-bit counter under random backpressure
        do_reset();
        ready_mode = 1;
        for (int f = 0; f < 17; f++) begin
            send_frame(make_frame(2));
        end
        wait_idle();
        check("t6_frame_count_wrap", 64'(frame_count), 64'd1);
        ready_mode = 0;

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
